instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter DEPTH, default 4: number of encoded-instruction FIFO entries; a power of two, at least 2.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000: byte address of the first emitted instruction.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  encoder can accept a request.
REQ-007 in_kind  input  2  0 = load, 1 = I-type ALU, 2 = store, 3 = reserved.
REQ-008 in_funct3  input  3  funct3 field.
REQ-009 in_rd / in_rs1 / in_rs2  input  5 each  register indices.
REQ-010 in_imm  input  32  signed immediate.
REQ-011 out_valid  output  1  encoded instruction present.
REQ-012 out_ready  input  1  consumer (instruction-memory writer) accepts.
REQ-013 out_instr  output  32  encoded instruction.
REQ-014 out_addr  output  32  byte address for out_instr.
REQ-015 err  output  1  one-cycle pulse when a request is rejected.
REQ-016 count  output  $clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-017 An input handshake occurs in a cycle with in_valid && in_ready; in_ready SHALL equal (count != DEPTH), with no combinational dependence on out_ready.
REQ-018 Load encoding SHALL be {imm[11:0], rs1, funct3, rd, 7'b0000011}.
REQ-019 I-type ALU encoding SHALL be {imm[11:0], rs1, funct3, rd, 7'b0010011}.
REQ-020 Store encoding SHALL be {imm[11:5], rs2, rs1, funct3, imm[4:0], 7'b0100011}.
REQ-021 For loads and I-type ALU requests, in_rs2 SHALL be ignored; for stores, in_rd SHALL be ignored.
REQ-022 A request with in_kind = 3 SHALL be consumed and dropped (no FIFO write), with err asserted for the following cycle.
REQ-023 Accepted requests SHALL be encoded combinationally and written to the FIFO tail; a request accepted in cycle N SHALL show out_valid = 1 no earlier than cycle N+1.
REQ-024 out_instr and out_addr SHALL come from the FIFO head; out_valid SHALL equal (count != 0).
REQ-025 The output handshake is out_valid && out_ready; it SHALL pop the head, and the address counter SHALL advance by 4.
REQ-026 out_addr SHALL equal BASE_ADDR + 4 × (number of completed output handshakes since reset), wrapping modulo 2^32.
REQ-027 A simultaneous push and pop SHALL leave count unchanged.
REQ-028 A simultaneous push and pop while count == DEPTH cannot occur, because in_ready = 0.
REQ-029 A pop and a rejected request in the same cycle SHALL decrement count by 1.
REQ-030 Read and write pointers SHALL wrap modulo DEPTH.
REQ-031 The FIFO SHALL preserve request order.
REQ-032 Outputs SHALL be stable while out_valid = 1 and out_ready = 0.

Reset
REQ-033 While rst = 1: count = 0, pointers = 0, address counter = BASE_ADDR, out_valid = 0, err = 0, in_ready = 0.
REQ-034 in_ready SHALL return to 1 in the first cycle after rst deasserts.
REQ-035 rst asserted mid-operation SHALL discard all FIFO contents and suppress any handshake in that cycle.
REQ-036 FIFO data storage need not be reset.

Configuration
REQ-037 With macro ENC_RANGE_CHECK_EN defined, a load, I-type or store request whose in_imm is not the sign extension of in_imm[11:0] SHALL be consumed, dropped and flagged with an err pulse, as in REQ-022.
REQ-038 Without ENC_RANGE_CHECK_EN, no range check SHALL be performed, and in_imm[11:0] SHALL be encoded silently.

Verification
REQ-039 Load request: rd = 5, rs1 = 2, funct3 = 3'b010, imm = 32'd8 -> out_instr = 32'h00812283, out_addr = BASE_ADDR.
REQ-040 Store request: rs2 = 5, rs1 = 2, funct3 = 3'b010, imm = -4 -> out_instr = 32'hFE512E23.
REQ-041 DEPTH + 1 back-to-back requests with out_ready = 0 -> in_ready = 0 once count = 4; then asserting out_ready drains the FIFO in order at addresses BASE_ADDR, +4, +8, +12.
REQ-042 I-type request with imm = 32'h0000_0800 -> with ENC_RANGE_CHECK_EN: err pulse, count unchanged; without it: out_instr[31:20] = 12'h800.
REQ-043 in_kind = 3 -> err pulse, no output; rst asserted with count = 3 -> the next cycle shows count = 0, out_valid = 0, and out_addr restarts at BASE_ADDR.

Source files
------------

// File: rtl/instr_encoder_if.sv
// instr_encoder_if: request/response bus between a producer of decoded fields and the encoder.
// The slave modport is the encoder view; master is the producer/consumer view.
interface instr_encoder_if #(
    parameter int DEPTH = 4
) ();
    logic                     in_valid;
    logic                     in_ready;
    logic [1:0]               in_kind;
    logic [2:0]               in_funct3;
    logic [4:0]               in_rd;
    logic [4:0]               in_rs1;
    logic [4:0]               in_rs2;
    logic [31:0]              in_imm;
    logic                     out_valid;
    logic                     out_ready;
    logic [31:0]              out_instr;
    logic [31:0]              out_addr;
    logic                     err;
    logic [$clog2(DEPTH):0]   count;

    modport slave (
        input  in_valid, in_kind, in_funct3, in_rd, in_rs1, in_rs2, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_addr, err, count
    );

    modport master (
        output in_valid, in_kind, in_funct3, in_rd, in_rs1, in_rs2, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_addr, err, count
    );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: encodes load/I-type/store requests into RV32 words, queued in a FIFO with byte addresses.
// Optional macro ENC_RANGE_CHECK_EN rejects immediates that do not fit in 12 signed bits.
module instr_encoder #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           rst,
    instr_encoder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic [31:0]   r_addr;
    logic          r_err;

    logic [11:0]   w_imm;
    logic [31:0]   w_instr;
    logic          w_reject;
    logic          w_in_ready;
    logic          w_out_valid;
    logic          w_in_hs;
    logic          w_push;
    logic          w_pop;

    always_comb begin
        w_imm   = bus.in_imm[11:0];
        w_instr = (bus.in_kind == 2'd2)
                ? {w_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, w_imm[4:0], 7'b0100011}
                : {w_imm, bus.in_rs1, bus.in_funct3, bus.in_rd,
                   (bus.in_kind == 2'd1) ? 7'b0010011 : 7'b0000011};
`ifdef ENC_RANGE_CHECK_EN
        w_reject = (bus.in_kind == 2'd3) || (bus.in_imm != {{20{w_imm[11]}}, w_imm});
`else
        w_reject = (bus.in_kind == 2'd3);
`endif
        // Reset gates both handshakes so nothing moves in a reset cycle.
        w_in_ready  = !rst && (r_count != (AW+1)'(DEPTH));
        w_out_valid = !rst && (r_count != '0);
        w_in_hs     = bus.in_valid && w_in_ready;
        w_push      = w_in_hs && !w_reject;
        w_pop       = w_out_valid && bus.out_ready;
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= w_instr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_addr  <= BASE_ADDR;
            r_err   <= 1'b0;
        end else begin
            r_err   <= w_in_hs && w_reject;
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
                r_addr <= r_addr + 32'd4;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_instr = r_mem[r_rptr];
    assign bus.out_addr  = r_addr;
    assign bus.err       = r_err;
    assign bus.count     = r_count;
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed checks of encoding, FIFO flow control, addressing, rejects and reset.
module tb_instr_encoder;
    localparam logic [31:0] BASE = 32'h0000_1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] exp_addr;

    always #5 clk = ~clk;

    instr_encoder_if #(.DEPTH(4)) bus ();

    instr_encoder #(.DEPTH(4), .BASE_ADDR(BASE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic req(input logic [1:0] kind, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm);
        bus.in_valid  = 1'b1;
        bus.in_kind   = kind;
        bus.in_rd     = rd;
        bus.in_rs1    = rs1;
        bus.in_rs2    = rs2;
        bus.in_funct3 = f3;
        bus.in_imm    = imm;
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_kind = 2'd0; bus.in_funct3 = 3'd0; bus.in_rd = 5'd0;
        bus.in_rs1 = 5'd0; bus.in_rs2 = 5'd0; bus.in_imm = 32'd0; bus.out_ready = 1'b0;
        step();
        step();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_addr", bus.out_addr, BASE);
        rst = 1'b0;
        step();
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        // load; rs2 must be ignored
        req(2'd0, 5'd5, 5'd2, 5'd7, 3'b010, 32'd8);
        chk("load_no_early_valid", 32'(bus.out_valid), 32'd0);
        step();
        bus.in_valid = 1'b0;
        chk("load_valid", 32'(bus.out_valid), 32'd1);
        chk("load_instr", bus.out_instr, 32'h0081_2283);
        chk("load_addr", bus.out_addr, BASE);
        chk("load_count", 32'(bus.count), 32'd1);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("pop_count", 32'(bus.count), 32'd0);
        chk("pop_valid", 32'(bus.out_valid), 32'd0);
        chk("pop_addr", bus.out_addr, BASE + 32'd4);

        // store; rd must be ignored
        req(2'd2, 5'd31, 5'd2, 5'd5, 3'b010, -32'sd4);
        step();
        chk("store_instr", bus.out_instr, 32'hFE51_2E23);
        chk("store_addr", bus.out_addr, BASE + 32'd4);

        // I-type pushed while the store pops
        req(2'd1, 5'd1, 5'd3, 5'd9, 3'b000, 32'hFFFF_FFFF);
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("pushpop_count", 32'(bus.count), 32'd1);
        chk("itype_instr", bus.out_instr, 32'hFFF1_8093);
        chk("itype_addr", bus.out_addr, BASE + 32'd8);
        step();
        bus.out_ready = 1'b0;
        chk("itype_pop_count", 32'(bus.count), 32'd0);
        exp_addr = BASE + 32'd12;

        // reserved kind
        req(2'd3, 5'd1, 5'd1, 5'd1, 3'd0, 32'd0);
        step();
        bus.in_valid = 1'b0;
        chk("rsv_err", 32'(bus.err), 32'd1);
        chk("rsv_count", 32'(bus.count), 32'd0);
        chk("rsv_valid", 32'(bus.out_valid), 32'd0);
        step();
        chk("rsv_err_pulse_end", 32'(bus.err), 32'd0);

        // 12-bit immediate overflow
        req(2'd1, 5'd0, 5'd0, 5'd0, 3'd0, 32'h0000_0800);
        step();
        bus.in_valid = 1'b0;
`ifdef ENC_RANGE_CHECK_EN
        chk("range_err", 32'(bus.err), 32'd1);
        chk("range_count", 32'(bus.count), 32'd0);
`else
        chk("range_err", 32'(bus.err), 32'd0);
        chk("range_count", 32'(bus.count), 32'd1);
        chk("range_instr", bus.out_instr, 32'h8000_0013);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        exp_addr = exp_addr + 32'd4;
`endif
        chk("range_addr", bus.out_addr, exp_addr);

        // DEPTH+1 back-to-back requests with the consumer stalled
        for (int i = 0; i < 5; i++) begin
            req(2'd0, 5'(i + 1), 5'd0, 5'd0, 3'd0, 32'd0);
            chk($sformatf("fill_in_ready_%0d", i), 32'(bus.in_ready), (i < 4) ? 32'd1 : 32'd0);
            step();
        end
        bus.in_valid = 1'b0;
        chk("full_count", 32'(bus.count), 32'd4);
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        step();
        chk("stall_instr", bus.out_instr, 32'h0000_0083);
        chk("stall_addr", bus.out_addr, exp_addr);
        bus.out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("drain_instr_%0d", j), bus.out_instr, (32'(j + 1) << 7) | 32'h3);
            chk($sformatf("drain_addr_%0d", j), bus.out_addr, exp_addr + 32'(4 * j));
            step();
        end
        bus.out_ready = 1'b0;
        exp_addr = exp_addr + 32'd16;
        chk("drained_count", 32'(bus.count), 32'd0);
        chk("drained_valid", 32'(bus.out_valid), 32'd0);

        // pop and reject in the same cycle
        req(2'd0, 5'd9, 5'd0, 5'd0, 3'd0, 32'd0);
        step();
        req(2'd3, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0);
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        chk("poprej_count", 32'(bus.count), 32'd0);
        chk("poprej_err", 32'(bus.err), 32'd1);
        chk("poprej_addr", bus.out_addr, exp_addr + 32'd4);

        // reset mid-operation with three entries queued
        for (int k = 0; k < 3; k++) begin
            req(2'd0, 5'(k + 1), 5'd0, 5'd0, 3'd0, 32'd0);
            step();
        end
        chk("pre_rst_count", 32'(bus.count), 32'd3);
        rst = 1'b1;
        bus.out_ready = 1'b1;
        step();
        chk("midrst_count", 32'(bus.count), 32'd0);
        chk("midrst_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        step();
        chk("after_rst_addr", bus.out_addr, BASE);
        chk("after_rst_count", 32'(bus.count), 32'd0);
        chk("after_rst_in_ready", 32'(bus.in_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
